// File: rtl/dac_output_stage.sv
// DAC output stage: offset, scale/saturate and slew-limit signed samples onto a
// 14-bit DAC bus, with an enable/ramp-down state machine and an underrun counter.
module dac_output_stage #(
  parameter int SLEW_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [15:0]       s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              enable_i,
  input  logic [15:0]       offset_i,
  input  logic [SLEW_W-1:0] slew_max_i,
  input  logic              clear_i,
  output logic [13:0]       dac_data_o,
  output logic              dac_valid_o,
  output logic              sat_o,
  output logic [CNT_W-1:0]  underrun_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int STAGES = 1;
  localparam int CW = (SLEW_W > 15) ? SLEW_W : 15;
  localparam logic signed [14:0] TMAX = 15'sd8191;
  localparam logic signed [14:0] TMIN = -15'sd8192;

  logic [1:0]         state, state_nx;
  logic [STAGES:0]    vld_pipe;
  logic signed [16:0] sum_q;
  logic signed [14:0] scl_q;
  logic signed [13:0] t_q, t_cl, y_q, y_nx;
  logic               sat_q, clip, run, accept;
  logic [CNT_W-1:0]   cnt_q;
  logic signed [14:0] d;
  logic [14:0]        absd;
  logic [CW-1:0]      slew_ext;
  logic [13:0]        step;

  assign run    = (state == S_RUN);
  assign accept = s_valid_i & run;

  always_comb begin
    clip = 1'b0;
    t_cl = scl_q[13:0];
    if (scl_q > TMAX) begin
      t_cl = 14'sd8191;
      clip = 1'b1;
    end else if (scl_q < TMIN) begin
      t_cl = -14'sd8192;
      clip = 1'b1;
    end
  end

  // Step toward the target by at most slew_max; a step never overshoots t
  // because it is only taken when |t - y| exceeds the slew limit.
  always_comb begin
    d        = {t_q[13], t_q} - {y_q[13], y_q};
    absd     = d[14] ? 15'(-d) : 15'(d);
    slew_ext = CW'(slew_max_i);
    step     = slew_ext[13:0];
    y_nx     = t_q;
    if (slew_ext != '0 && CW'(absd) > slew_ext)
      y_nx = d[14] ? (y_q - step) : (y_q + step);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (enable_i) state_nx = S_RUN;
      S_RUN:   if (!enable_i) state_nx = S_DRAIN;
      S_DRAIN: if (enable_i) state_nx = S_RUN;
               else if (y_q == '0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= S_IDLE;
      vld_pipe <= '0;
      sum_q    <= '0;
      scl_q    <= '0;
      t_q      <= '0;
      sat_q    <= 1'b0;
      y_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state <= state_nx;
      // Outside RUN the target is parked at zero and in-flight samples dropped.
      if (!run) begin
        vld_pipe <= '0;
        t_q      <= '0;
        sat_q    <= 1'b0;
      end else begin
        vld_pipe <= {vld_pipe[STAGES-1:0], accept};
        if (accept)
          sum_q <= {s_data_i[15], s_data_i} + {offset_i[15], offset_i};
        if (vld_pipe[0])
          scl_q <= 15'(sum_q >>> 2);
        if (vld_pipe[1]) begin
          t_q   <= t_cl;
          sat_q <= clip;
        end else begin
          sat_q <= 1'b0;
        end
      end
      y_q <= (state == S_IDLE) ? '0 : y_nx;
      if (clear_i)
        cnt_q <= '0;
      else if (run && !s_valid_i && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign s_ready_o      = run;
  assign dac_valid_o    = (state != S_IDLE);
  assign dac_data_o     = y_q;
  assign sat_o          = sat_q;
  assign underrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_dac_output_stage.sv
// Bench for dac_output_stage: vector table, directed multi-cycle sequences and a
// randomized stream checked against an arithmetic reference model.
module tb_dac_output_stage;
  logic clk = 1'b0;
  logic rstn;
  logic [15:0] s_data, offset;
  logic s_valid, enable, clear;
  logic [13:0] slew;
  logic s_ready, dac_valid, sat;
  logic signed [13:0] dac_data;
  logic [15:0] cnt;
  logic s_ready_s, dac_valid_s, sat_s;
  logic signed [13:0] dac_data_s;
  logic [3:0] cnt_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dac_output_stage #(.SLEW_W(14), .CNT_W(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .s_data_i(s_data), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .enable_i(enable), .offset_i(offset), .slew_max_i(slew),
    .clear_i(clear), .dac_data_o(dac_data), .dac_valid_o(dac_valid), .sat_o(sat),
    .underrun_cnt_o(cnt));

  // Narrow counter copy to reach counter saturation quickly.
  dac_output_stage #(.SLEW_W(14), .CNT_W(4)) dut_s (
    .clk_i(clk), .rstn_i(rstn), .s_data_i(s_data), .s_valid_i(s_valid),
    .s_ready_o(s_ready_s), .enable_i(enable), .offset_i(offset), .slew_max_i(slew),
    .clear_i(clear), .dac_data_o(dac_data_s), .dac_valid_o(dac_valid_s), .sat_o(sat_s),
    .underrun_cnt_o(cnt_s));

  typedef struct {
    logic [15:0] d;
    logic [15:0] off;
    int          exp;
    int          esat;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_data = '0; s_valid = 1'b0; enable = 1'b0;
    offset = '0; slew = '0; clear = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic go_run();
    enable = 1'b1;
    tick();
  endtask

  task automatic feed(input logic [15:0] dv);
    s_data = dv; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  function automatic int floor4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic int clamp14(input int v);
    return (v > 8191) ? 8191 : (v < -8192) ? -8192 : v;
  endfunction

  function automatic int lim(input int y, input int t, input int s);
    if (s == 0) return t;
    if (t - y > s) return y + s;
    if (t - y < -s) return y - s;
    return t;
  endfunction

  int acc_v[0:401];
  bit acc_h[0:401];
  bit acc_c[0:401];

  initial begin
    int ym, tm, satm, um, sk, raw, sd, so;
    tbl[0] = '{16'h4000, 16'h0000, 4096, 0};
    tbl[1] = '{16'h8000, 16'h0000, -8192, 0};
    tbl[2] = '{16'h7FFF, 16'h0000, 8191, 0};
    tbl[3] = '{16'h7000, 16'h7000, 8191, 1};
    tbl[4] = '{16'h0000, 16'hFFFF, -1, 0};
    tbl[5] = '{16'h8000, 16'h8000, -8192, 1};
    tbl[6] = '{16'h0003, 16'h0000, 0, 0};
    tbl[7] = '{16'hFFFD, 16'h0000, -1, 0};
    tbl[8] = '{16'h7FFF, 16'h7FFF, 8191, 1};

    // Reset state
    do_reset();
    chk("rst_data", dac_data, 0);
    chk("rst_valid", dac_valid, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_sat", sat, 0);
    chk("rst_cnt", cnt, 0);
    go_run();
    chk("run_ready", s_ready, 1);
    chk("run_valid", dac_valid, 1);

    // Vector table: one sample each, sat at N+2, data at N+3
    for (int i = 0; i < 9; i++) begin
      offset = tbl[i].off;
      feed(tbl[i].d);
      tick(); tick();
      chk($sformatf("vec%0d_sat", i), sat, tbl[i].esat);
      tick();
      chk($sformatf("vec%0d_data", i), dac_data, tbl[i].exp);
      chk($sformatf("vec%0d_sat_off", i), sat, 0);
    end

    // Slew limiting: 0 -> 2048 at 100 per step
    do_reset(); go_run();
    slew = 14'd100;
    feed(16'h2000);
    tick(); tick();
    for (int i = 1; i <= 21; i++) begin
      tick();
      chk($sformatf("slew_step%0d", i), dac_data, (100 * i < 2048) ? 100 * i : 2048);
    end
    tick();
    chk("slew_hold", dac_data, 2048);

    // Ramp-down from 8191 at 1000 per step
    do_reset(); go_run();
    feed(16'h7FFF);
    tick(); tick(); tick();
    chk("ramp_pre", dac_data, 8191);
    slew = 14'd1000;
    enable = 1'b0;
    tick();
    chk("ramp_ready_fall", s_ready, 0);
    chk("ramp_valid_drain", dac_valid, 1);
    tick();
    chk("ramp_hold", dac_data, 8191);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("ramp_step%0d", i), dac_data, (8191 - 1000 * i > 0) ? 8191 - 1000 * i : 0);
    end
    chk("ramp_valid_at_zero", dac_valid, 1);
    tick();
    chk("ramp_valid_fall", dac_valid, 0);
    chk("ramp_idle_ready", s_ready, 0);

    // Re-enable mid-ramp
    slew = '0;
    go_run();
    feed(16'h7FFF);
    tick(); tick(); tick();
    slew = 14'd1000;
    enable = 1'b0;
    tick(); tick(); tick(); tick();
    chk("reen_mid", dac_data, 6191);
    enable = 1'b1;
    tick();
    chk("reen_ready", s_ready, 1);
    chk("reen_valid", dac_valid, 1);
    chk("reen_data", dac_data, 5191);

    // Enable returns in the same cycle DRAIN would exit to IDLE
    do_reset(); go_run();
    feed(16'h1000);
    tick(); tick(); tick();
    chk("simul_pre", dac_data, 1024);
    enable = 1'b0;
    tick(); tick(); tick();
    chk("simul_zero", dac_data, 0);
    chk("simul_drain", dac_valid, 1);
    enable = 1'b1;
    tick();
    chk("simul_ready", s_ready, 1);
    chk("simul_valid", dac_valid, 1);

    // Underrun counting, clear priority and saturation
    do_reset(); go_run();
    feed(16'h1000);
    repeat (5) tick();
    chk("under_cnt5", cnt, 5);
    chk("under_hold", dac_data, 1024);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("under_clear", cnt, 0);
    chk("under_clear_s", cnt_s, 0);
    repeat (20) tick();
    chk("under_cnt20", cnt, 20);
    chk("under_sat_s", cnt_s, 15);

    // Asynchronous reset in the middle of a slew ramp
    do_reset(); go_run();
    slew = 14'd10;
    feed(16'h2000);
    repeat (5) tick();
    chk("areset_pre", dac_data, 30);
    #2 rstn = 1'b0;
    #1;
    chk("areset_data", dac_data, 0);
    chk("areset_valid", dac_valid, 0);
    chk("areset_ready", s_ready, 0);
    chk("areset_cnt", cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    slew = '0;
    enable = 1'b0;
    tick();
    chk("areset_idle", dac_valid, 0);
    go_run();
    feed(16'h1000);
    tick(); tick(); tick();
    chk("areset_first", dac_data, 1024);

    // Randomized stream in RUN against the reference model
    do_reset(); go_run();
    ym = 0; tm = 0; um = 0;
    for (int k = 1; k <= 400; k++) begin
      s_valid = ($urandom_range(0, 4) != 0);
      s_data = 16'($urandom);
      offset = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
      case ($urandom_range(0, 3))
        0: sk = 0;
        1: sk = $urandom_range(1, 300);
        2: sk = $urandom_range(1, 5000);
        default: sk = 16383;
      endcase
      slew = 14'(sk);
      sd = int'($signed(s_data));
      so = int'($signed(offset));
      raw = floor4(sd + so);
      acc_h[k] = s_valid;
      acc_v[k] = clamp14(raw);
      acc_c[k] = (raw != clamp14(raw));
      if (!s_valid) um++;
      tick();
      ym = lim(ym, tm, sk);
      satm = 0;
      if (k >= 3 && acc_h[k-2]) begin
        tm = acc_v[k-2];
        satm = acc_c[k-2];
      end
      chk($sformatf("rnd%0d_data", k), dac_data, ym);
      chk($sformatf("rnd%0d_sat", k), sat, satm);
    end
    s_valid = 1'b0;
    chk("rnd_cnt", cnt, um);
    chk("rnd_cnt_s", cnt_s, (um > 15) ? 15 : um);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
